// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: register IDs and control bits
// come in from the pipeline, and stall/flush/forward selects go back out.
interface hazard_unit_if;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic [4:0] WriteRegM;
    logic [4:0] WriteRegW;
    logic       RegWriteE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemtoRegE;
    logic       MemtoRegM;
    logic       BranchD;
    logic       MemAccessM;
    logic       dmem_ready;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushE;
    logic       FlushW;
    logic       ForwardAD;
    logic       ForwardBD;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;

    // The pipeline side drives the operand/control view and receives the controls.
    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, MemAccessM, dmem_ready,
        input  StallF, StallD, StallE, StallM, FlushE, FlushW,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, MemAccessM, dmem_ready,
        output StallF, StallD, StallE, StallM, FlushE, FlushW,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: same-cycle stall/flush and
// forwarding decode, plus a registered hazard history, counters and watchdog.
module hazard_unit #(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_cnt,
    hazard_unit_if.slave     hz,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             watchdog_err
);

    typedef enum logic [1:0] {
        RUN = 2'b00,
        LU  = 2'b01,
        BR  = 2'b10,
        MW  = 2'b11
    } hz_state_t;

    localparam int  WD_W  = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
    localparam bit  WD_EN = (WDOG_LIMIT > 0);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(WDOG_LIMIT);
    localparam logic [WD_W:0]   WD_LIMIT = (WD_W + 1)'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t state_q;
    hz_state_t state_d;

    logic memwait;
    logic lwstall;
    logic brstall;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_e;
    logic flush_w;

    logic [WD_W-1:0] consec_q;
    logic [WD_W:0]   consec_inc;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_ex(input logic [4:0] src,
                                          input logic       wr_m,
                                          input logic [4:0] dst_m,
                                          input logic       wr_w,
                                          input logic [4:0] dst_w);
        if (wr_m && reg_match(dst_m, src))
            return 2'b10;
        else if (wr_w && reg_match(dst_w, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        memwait = hz.MemAccessM && !hz.dmem_ready;
        lwstall = hz.MemtoRegE &&
                  (reg_match(hz.RtE, hz.RsD) || reg_match(hz.RtE, hz.RtD));
        brstall = hz.BranchD &&
                  ((hz.RegWriteE &&
                    (reg_match(hz.WriteRegE, hz.RsD) || reg_match(hz.WriteRegE, hz.RtD))) ||
                   (hz.MemtoRegM &&
                    (reg_match(hz.WriteRegM, hz.RsD) || reg_match(hz.WriteRegM, hz.RtD))));
    end

    // Highest-priority hazard picks both the controls and the next history state.
    always_comb begin
        state_d = RUN;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (memwait) begin
            state_d = MW;
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (lwstall) begin
            state_d = LU;
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (brstall) begin
            state_d = BR;
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
        if (!rst_n) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_e = 1'b0;
            flush_w = 1'b0;
        end
    end

    always_comb begin
        hz.StallF    = stall_f;
        hz.StallD    = stall_d;
        hz.StallE    = stall_e;
        hz.StallM    = stall_m;
        hz.FlushE    = flush_e;
        hz.FlushW    = flush_w;
        hz.ForwardAD = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsD);
        hz.ForwardBD = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtD);
        hz.ForwardAE = fwd_ex(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardBE = fwd_ex(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    assign hz_state = state_q;

    // Clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_e && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign consec_inc = {1'b0, consec_q} + (WD_W + 1)'(1);

    // The run-length counter ignores clr_cnt so software cannot mask a hang.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_q     <= '0;
            watchdog_err <= 1'b0;
        end else begin
            if (!stall_f)
                consec_q <= '0;
            else if (consec_q != WD_MAX)
                consec_q <= consec_q + WD_W'(1);
            if (WD_EN && stall_f && (consec_inc >= WD_LIMIT))
                watchdog_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_hazard_unit;

    localparam int CNT_W      = 3;
    localparam int WDOG_LIMIT = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
        logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
        logic       BranchD, MemAccessM, dmem_ready, clr_cnt, rst_n;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             watchdog_err;

    hazard_unit_if hz ();

    hazard_unit #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_cnt      (clr_cnt),
        .hz           (hz),
        .hz_state     (hz_state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .watchdog_err (watchdog_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    stim_t cur;
    int    m_state, m_stall, m_flush, m_consec;
    bit    m_err;

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    // 0 none, 1 load-use, 2 branch, 3 memory wait (also the hz_state code)
    function automatic int hazardKind(input stim_t s);
        if (s.MemAccessM && !s.dmem_ready) return 3;
        if (s.MemtoRegE && (hit(s.RtE, s.RsD) || hit(s.RtE, s.RtD))) return 1;
        if (s.BranchD && ((s.RegWriteE && (hit(s.WriteRegE, s.RsD) || hit(s.WriteRegE, s.RtD))) ||
                          (s.MemtoRegM && (hit(s.WriteRegM, s.RsD) || hit(s.WriteRegM, s.RtD)))))
            return 2;
        return 0;
    endfunction

    function automatic logic [1:0] fwdE(input stim_t s, input logic [4:0] src);
        if (s.RegWriteM && hit(s.WriteRegM, src)) return 2'd2;
        if (s.RegWriteW && hit(s.WriteRegW, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.dmem_ready = 1'b1;
        s.rst_n      = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.RsD        = 5'($urandom_range(0, 3));
        s.RtD        = 5'($urandom_range(0, 3));
        s.RsE        = 5'($urandom_range(0, 3));
        s.RtE        = 5'($urandom_range(0, 3));
        s.WriteRegE  = 5'($urandom_range(0, 3));
        s.WriteRegM  = 5'($urandom_range(0, 3));
        s.WriteRegW  = 5'($urandom_range(0, 3));
        s.RegWriteE  = ($urandom_range(0, 1) == 1);
        s.RegWriteM  = ($urandom_range(0, 1) == 1);
        s.RegWriteW  = ($urandom_range(0, 1) == 1);
        s.MemtoRegE  = ($urandom_range(0, 2) == 0);
        s.MemtoRegM  = ($urandom_range(0, 2) == 0);
        s.BranchD    = ($urandom_range(0, 2) == 0);
        s.MemAccessM = ($urandom_range(0, 3) == 0);
        s.dmem_ready = ($urandom_range(0, 2) != 0);
        s.clr_cnt    = ($urandom_range(0, 9) == 0);
        s.rst_n      = ($urandom_range(0, 24) != 0);
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one vector at the falling edge and check everything visible before the next rise.
    task automatic applyStimulus(input stim_t s);
        int         k;
        logic [5:0] exp_ctl;
        @(negedge clk);
        cur          = s;
        hz.RsD       = s.RsD;        hz.RtD       = s.RtD;
        hz.RsE       = s.RsE;        hz.RtE       = s.RtE;
        hz.WriteRegE = s.WriteRegE;  hz.WriteRegM = s.WriteRegM;
        hz.WriteRegW = s.WriteRegW;  hz.RegWriteE = s.RegWriteE;
        hz.RegWriteM = s.RegWriteM;  hz.RegWriteW = s.RegWriteW;
        hz.MemtoRegE = s.MemtoRegE;  hz.MemtoRegM = s.MemtoRegM;
        hz.BranchD   = s.BranchD;    hz.MemAccessM = s.MemAccessM;
        hz.dmem_ready = s.dmem_ready;
        clr_cnt      = s.clr_cnt;
        rst_n        = s.rst_n;
        if (!s.rst_n) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_err = 1'b0;
        end
        #1;
        k = hazardKind(s);
        if (!s.rst_n || k == 0) exp_ctl = 6'b000000;
        else if (k == 3)        exp_ctl = 6'b111101;
        else                    exp_ctl = 6'b110010;
        checkOutput("ctl", {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushE, hz.FlushW},
                    {26'd0, exp_ctl});
        checkOutput("fwdAE", {30'd0, hz.ForwardAE}, {30'd0, fwdE(s, s.RsE)});
        checkOutput("fwdBE", {30'd0, hz.ForwardBE}, {30'd0, fwdE(s, s.RtE)});
        checkOutput("fwdAD", {31'd0, hz.ForwardAD}, {31'd0, s.RegWriteM && hit(s.WriteRegM, s.RsD)});
        checkOutput("fwdBD", {31'd0, hz.ForwardBD}, {31'd0, s.RegWriteM && hit(s.WriteRegM, s.RtD)});
        checkOutput("state", {30'd0, hz_state}, 32'(m_state));
        checkOutput("stall_cnt", {29'd0, stall_cnt}, 32'(m_stall));
        checkOutput("flush_cnt", {29'd0, flush_cnt}, 32'(m_flush));
        checkOutput("wdog", {31'd0, watchdog_err}, {31'd0, m_err});
    endtask

    task automatic stepClock();
        int k;
        @(posedge clk);
        if (cur.rst_n) begin
            k       = hazardKind(cur);
            m_state = k;
            if (cur.clr_cnt) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (k != 0)           m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
                if (k == 1 || k == 2) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            end
            m_consec = (k != 0) ? ((m_consec < WDOG_LIMIT) ? m_consec + 1 : WDOG_LIMIT) : 0;
            if (WDOG_LIMIT > 0 && m_consec >= WDOG_LIMIT) m_err = 1'b1;
        end
    endtask

    task automatic runCycle(input stim_t s);
        applyStimulus(s);
        stepClock();
    endtask

    initial begin
        stim_t s, mw;
        m_state = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_err = 1'b0;
        cur = idle();

        s = idle(); s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("rst_state", {30'd0, hz_state}, 32'd0);
        checkOutput("rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        stepClock();

        // Forwarding priority: MEM beats WB, $0 never forwards.
        s = idle(); s.RsE = 5; s.RegWriteM = 1; s.WriteRegM = 5; s.RegWriteW = 1; s.WriteRegW = 5;
        applyStimulus(s); checkOutput("fwd_mem", {30'd0, hz.ForwardAE}, 32'd2); stepClock();
        s.RegWriteM = 0;
        applyStimulus(s); checkOutput("fwd_wb", {30'd0, hz.ForwardAE}, 32'd1); stepClock();
        s.RsE = 0; s.WriteRegM = 0; s.RegWriteM = 1;
        applyStimulus(s); checkOutput("fwd_r0", {30'd0, hz.ForwardAE}, 32'd0); stepClock();

        // Load-use stall then registered history.
        s = idle(); s.MemtoRegE = 1; s.RtE = 8; s.RsD = 8;
        applyStimulus(s);
        checkOutput("lu_stallF", {31'd0, hz.StallF}, 32'd1);
        checkOutput("lu_flushE", {31'd0, hz.FlushE}, 32'd1);
        stepClock();
        applyStimulus(idle());
        checkOutput("lu_state", {30'd0, hz_state}, 32'd1);
        checkOutput("lu_cnts", {26'd0, flush_cnt, stall_cnt}, {26'd0, 3'd1, 3'd1});
        stepClock();

        // Branch stall via EX writer, then MEM load, then plain ID forward.
        s = idle(); s.BranchD = 1; s.RsD = 3; s.RegWriteE = 1; s.WriteRegE = 3;
        runCycle(s);
        s.RegWriteE = 0; s.MemtoRegM = 1; s.RegWriteM = 1; s.WriteRegM = 3;
        applyStimulus(s);
        checkOutput("br_state", {30'd0, hz_state}, 32'd2);
        checkOutput("br_hold", {31'd0, hz.StallD}, 32'd1);
        stepClock();
        s.MemtoRegM = 0;
        applyStimulus(s);
        checkOutput("br_fwdAD", {30'd0, hz.ForwardAD, hz.StallF}, 32'b10);
        stepClock();

        // Memory wait dominates a load-use; watchdog fires after four stalled edges.
        s = idle(); s.rst_n = 1'b0; runCycle(s);
        mw = idle(); mw.MemAccessM = 1; mw.dmem_ready = 0; mw.MemtoRegE = 1; mw.RtE = 8; mw.RsD = 8;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mw);
            checkOutput("mw_ctl", {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushE, hz.FlushW},
                        32'b111101);
            stepClock();
        end
        s = idle(); s.clr_cnt = 1;
        applyStimulus(s);
        checkOutput("mw_state", {30'd0, hz_state}, 32'd3);
        checkOutput("mw_wdog", {31'd0, watchdog_err}, 32'd1);
        stepClock();
        applyStimulus(idle());
        checkOutput("wdog_sticky", {31'd0, watchdog_err}, 32'd1);
        checkOutput("clr_cnt", {29'd0, stall_cnt}, 32'd0);
        stepClock();
        s = idle(); s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("wdog_rst", {31'd0, watchdog_err}, 32'd0);
        stepClock();

        // Counter saturation, clear against increment, reset mid-stall.
        for (int i = 0; i < 9; i++) runCycle(mw);
        applyStimulus(mw);
        checkOutput("sat", {29'd0, stall_cnt}, 32'(CNT_MAX));
        s = mw; s.clr_cnt = 1;
        stepClock();
        applyStimulus(s); stepClock();
        applyStimulus(mw);
        checkOutput("clr_wins", {29'd0, stall_cnt}, 32'd0);
        stepClock();
        s = mw; s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("rst_mid_stall", {28'd0, hz.StallF, stall_cnt}, 32'd0);
        stepClock();

        for (int i = 0; i < 2000; i++) runCycle(randStim());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
